// File: rtl/dram_arbiter.sv
// dram_arbiter
//   Round-robin arbiter giving four cores shared access to one single-port
//   DRAM. Each access takes IDLE (grant) -> ACCESS (strobe) -> RESP (capture),
//   and the winning core's ack is raised in the cycle after RESP.
//
// Ports (n = 0..3)
//   clk, rst           single clock, synchronous active-high reset
//   req_n, we_n        core request (level) and write enable
//   addr_n, wdata_n    core address / write data, sampled only at grant
//   end_n              core finished, removed from arbitration
//   ack_n              one-cycle completion pulse
//   rdata_n            last data returned to core n, held until its next access
//   mem_addr/we/wdata  registered DRAM command
//   mem_rdata          DRAM read data, one cycle after mem_addr
//   grant_id           current / last granted core
//   busy               high in ACCESS and RESP
module dram_arbiter #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_0,
   input  logic              req_1,
   input  logic              req_2,
   input  logic              req_3,
   input  logic              we_0,
   input  logic              we_1,
   input  logic              we_2,
   input  logic              we_3,
   input  logic [ADDR_W-1:0] addr_0,
   input  logic [ADDR_W-1:0] addr_1,
   input  logic [ADDR_W-1:0] addr_2,
   input  logic [ADDR_W-1:0] addr_3,
   input  logic [DATA_W-1:0] wdata_0,
   input  logic [DATA_W-1:0] wdata_1,
   input  logic [DATA_W-1:0] wdata_2,
   input  logic [DATA_W-1:0] wdata_3,
   input  logic              end_0,
   input  logic              end_1,
   input  logic              end_2,
   input  logic              end_3,
   output logic              ack_0,
   output logic              ack_1,
   output logic              ack_2,
   output logic              ack_3,
   output logic [DATA_W-1:0] rdata_0,
   output logic [DATA_W-1:0] rdata_1,
   output logic [DATA_W-1:0] rdata_2,
   output logic [DATA_W-1:0] rdata_3,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [1:0]        grant_id,
   output logic              busy
);

   localparam int NCORE = 4;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

   state_e                         state_q, state_d;
   logic [1:0]                     last_grant_q, last_grant_d;
   logic [1:0]                     grant_q, grant_d;
   logic [NCORE-1:0]               ack_q, ack_d;
   logic [NCORE-1:0][DATA_W-1:0]   rdata_q, rdata_d;
   logic [ADDR_W-1:0]              mem_addr_q, mem_addr_d;
   logic                           mem_we_q, mem_we_d;
   logic [DATA_W-1:0]              mem_wdata_q, mem_wdata_d;

   // Per-core inputs gathered into packed arrays so the arbiter can index them.
   logic [NCORE-1:0]               req_a, we_a, end_a, elig;
   logic [NCORE-1:0][ADDR_W-1:0]   addr_a;
   logic [NCORE-1:0][DATA_W-1:0]   wdata_a;
   logic                           found;
   logic [1:0]                     win;

   assign req_a   = {req_3, req_2, req_1, req_0};
   assign we_a    = {we_3, we_2, we_1, we_0};
   assign end_a   = {end_3, end_2, end_1, end_0};
   assign addr_a  = {addr_3, addr_2, addr_1, addr_0};
   assign wdata_a = {wdata_3, wdata_2, wdata_1, wdata_0};

   // A core being acked this cycle is excluded, so a held request is treated
   // as a fresh one only from the cycle after its ack.
   assign elig = req_a & ~end_a & ~ack_q;

   // Round-robin search starting one past the last completed grant; the
   // 2-bit add wraps 3 -> 0 naturally, and the last grantee is tried last.
   always_comb begin
      logic [1:0] cand;
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int k = 1; k <= NCORE; k++) begin
         cand = last_grant_q + 2'(k);
         if (!found && elig[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      ack_d        = '0;
      rdata_d      = rdata_q;
      mem_addr_d   = mem_addr_q;
      mem_we_d     = 1'b0;
      mem_wdata_d  = mem_wdata_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               mem_addr_d  = addr_a[win];
               mem_we_d    = we_a[win];
               mem_wdata_d = wdata_a[win];
               grant_d     = win;
               state_d     = ACCESS;
            end
         end
         ACCESS: begin
            // Command was on the bus for this one cycle; strobe drops now.
            state_d = RESP;
         end
         RESP: begin
            // DRAM data for the ACCESS-cycle address is valid now.
            rdata_d[grant_q] = mem_rdata;
            last_grant_d     = grant_q;
            ack_d[grant_q]   = 1'b1;
            state_d          = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= 2'd3;
         grant_q      <= '0;
         ack_q        <= '0;
         rdata_q      <= '0;
         mem_addr_q   <= '0;
         mem_we_q     <= 1'b0;
         mem_wdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         ack_q        <= ack_d;
         rdata_q      <= rdata_d;
         mem_addr_q   <= mem_addr_d;
         mem_we_q     <= mem_we_d;
         mem_wdata_q  <= mem_wdata_d;
      end
   end

   assign ack_0     = ack_q[0];
   assign ack_1     = ack_q[1];
   assign ack_2     = ack_q[2];
   assign ack_3     = ack_q[3];
   assign rdata_0   = rdata_q[0];
   assign rdata_1   = rdata_q[1];
   assign rdata_2   = rdata_q[2];
   assign rdata_3   = rdata_q[3];
   assign mem_addr  = mem_addr_q;
   assign mem_we    = mem_we_q;
   assign mem_wdata = mem_wdata_q;
   assign grant_id  = grant_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter
//   Directed scenarios plus a randomized run against a transaction-level
//   model: a grant is decided whenever the arbiter is free, it occupies the
//   bus for 3 cycles, and its ack / data land 2 edges after the grant.
module tb_dram_arbiter;
   localparam int AW = 12, DW = 32, MAXC = 4096, MEMSZ = 1 << AW;

   logic clk = 1'b0, rst = 1'b1, mem_clr = 1'b1;
   logic [3:0] req = '0, we = '0, en = '0;
   logic [3:0][AW-1:0] addr = '0;
   logic [3:0][DW-1:0] wdata = '0;
   logic [3:0] ack;
   logic [3:0][DW-1:0] rdata;
   logic [AW-1:0] mem_addr;
   logic mem_we, busy;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic [1:0] grant_id;
   int checks = 0, errors = 0, cyc = 0;

   dram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst),
      .req_0(req[0]), .req_1(req[1]), .req_2(req[2]), .req_3(req[3]),
      .we_0(we[0]), .we_1(we[1]), .we_2(we[2]), .we_3(we[3]),
      .addr_0(addr[0]), .addr_1(addr[1]), .addr_2(addr[2]), .addr_3(addr[3]),
      .wdata_0(wdata[0]), .wdata_1(wdata[1]), .wdata_2(wdata[2]), .wdata_3(wdata[3]),
      .end_0(en[0]), .end_1(en[1]), .end_2(en[2]), .end_3(en[3]),
      .ack_0(ack[0]), .ack_1(ack[1]), .ack_2(ack[2]), .ack_3(ack[3]),
      .rdata_0(rdata[0]), .rdata_1(rdata[1]), .rdata_2(rdata[2]), .rdata_3(rdata[3]),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .grant_id(grant_id), .busy(busy));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Single-port DRAM, registered read; a write returns the written data.
   logic [DW-1:0] dram [MEMSZ];
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < MEMSZ; i++) dram[i] <= DW'(i) * 32'h9E3779B1;
         mem_rdata <= '0;
      end else begin
         if (mem_we) dram[mem_addr] <= mem_wdata;
         mem_rdata <= mem_we ? mem_wdata : dram[mem_addr];
      end
   end

   // Reference model state
   logic [3:0]    exp_ack  [MAXC];
   logic          exp_busy [MAXC];
   logic          exp_we   [MAXC];
   logic          exp_g    [MAXC];
   logic [AW-1:0] exp_addr [MAXC];
   logic [DW-1:0] exp_wd   [MAXC];
   logic [1:0]    exp_gid  [MAXC];
   logic [DW-1:0] ref_mem  [MEMSZ];
   int free_at = 0, last_g = 3;
   logic [1:0] m_gid = '0;
   logic [3:0][DW-1:0] m_rd = '0;
   int pend_cyc [4];
   logic [DW-1:0] pend_val [4];

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Predict the effect of edge k given the inputs currently driven.
   task automatic model_edge(int k);
      int w;
      w = -1;
      if (rst) begin
         for (int j = k; j < k + 3; j++) begin
            exp_ack[j] = '0; exp_busy[j] = 0; exp_we[j] = 0; exp_g[j] = 0;
         end
         free_at = k + 1; last_g = 3; m_gid = '0; m_rd = '0;
         for (int c = 0; c < 4; c++) pend_cyc[c] = -1;
      end else if (k >= free_at) begin
         for (int i = 1; i <= 4; i++) begin
            int c;
            c = (last_g + i) % 4;
            if (w < 0 && req[c] && !en[c] && !exp_ack[k-1][c]) w = c;
         end
         if (w >= 0) begin
            exp_g[k] = 1; exp_we[k] = we[w]; exp_addr[k] = addr[w]; exp_wd[k] = wdata[w];
            exp_busy[k] = 1; exp_busy[k+1] = 1; exp_ack[k+2][w] = 1'b1;
            m_gid = 2'(w); last_g = w; free_at = k + 3;
            if (we[w]) begin
               ref_mem[addr[w]] = wdata[w];
               pend_val[w] = wdata[w];
            end else pend_val[w] = ref_mem[addr[w]];
            pend_cyc[w] = k + 2;
         end
      end
      exp_gid[k] = m_gid;
   endtask

   task automatic test_reset();
      rst = 1'b1; mem_clr = 1'b1;
      step(); step();
      mem_clr = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b exp 0", mem_we); end
      checks++; if (ack !== 4'b0) begin errors++; $display("FAIL reset_ack: got %b exp 0000", ack); end
      checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_gid: got %0d exp 0", grant_id); end
      checks++; if (mem_addr !== '0 || mem_wdata !== '0) begin errors++; $display("FAIL reset_mem: got addr %h wdata %h exp 0", mem_addr, mem_wdata); end
      checks++; if (rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %h exp 0", rdata); end
   endtask

   task automatic test_single_write();
      rst = 1'b0;
      req[1] = 1'b1; we[1] = 1'b1; addr[1] = 12'h010; wdata[1] = 32'hDEADBEEF;
      step();
      checks++; if (mem_we !== 1'b1 || mem_addr !== 12'h010 || mem_wdata !== 32'hDEADBEEF)
         begin errors++; $display("FAIL wr_cmd: got we %b addr %h data %h exp 1 010 deadbeef", mem_we, mem_addr, mem_wdata); end
      checks++; if (grant_id !== 2'd1 || busy !== 1'b1) begin errors++; $display("FAIL wr_grant: got gid %0d busy %b exp 1 1", grant_id, busy); end
      step();
      checks++; if (mem_we !== 1'b0 || ack !== 4'b0 || busy !== 1'b1) begin errors++; $display("FAIL wr_resp: got we %b ack %b busy %b exp 0 0000 1", mem_we, ack, busy); end
      step();
      checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL wr_ack: got %b exp 0010", ack); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_idle: got busy %b exp 0", busy); end
      req[1] = 1'b0; we[1] = 1'b0;
      step();
      checks++; if (ack !== 4'b0) begin errors++; $display("FAIL wr_pulse: got %b exp 0000", ack); end
      checks++; if (rdata[1] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_hold: got %h exp deadbeef", rdata[1]); end
   endtask

   task automatic test_readback();
      for (int c = 1; c >= 0; c--) begin
         req[c] = 1'b1; we[c] = 1'b0; addr[c] = 12'h010; wdata[c] = '0;
         step();
         checks++; if (mem_we !== 1'b0 || mem_addr !== 12'h010) begin errors++; $display("FAIL rd_cmd%0d: got we %b addr %h exp 0 010", c, mem_we, mem_addr); end
         step(); step();
         checks++; if (ack[c] !== 1'b1 || rdata[c] !== 32'hDEADBEEF)
            begin errors++; $display("FAIL rd_data%0d: got ack %b data %h exp 1 deadbeef", c, ack[c], rdata[c]); end
         req[c] = 1'b0;
         step();
      end
   endtask

   // All cores request from reset; end_mask removes some from arbitration.
   task automatic run_contention(string nm, logic [3:0] end_mask, int nacks, int steps);
      int order[$], at[$];
      int c0, exp_c;
      rst = 1'b1; req = '0; en = '0; step();
      rst = 1'b0; c0 = cyc; en = end_mask; req = 4'hF; we = '0;
      for (int c = 0; c < 4; c++) addr[c] = AW'(32 + c);
      for (int i = 0; i < steps; i++) begin
         step();
         checks++;
         if ($countones(ack) > 1 || (ack & end_mask) != 4'b0) begin errors++; $display("FAIL %s_ack_onehot: got %b", nm, ack); end
         for (int c = 0; c < 4; c++) if (ack[c]) begin order.push_back(c); at.push_back(cyc); end
      end
      checks++;
      if (order.size() != nacks) begin errors++; $display("FAIL %s_count: got %0d exp %0d", nm, order.size(), nacks); end
      else begin
         exp_c = 0;
         checks++; if (at[0] != c0 + 3) begin errors++; $display("FAIL %s_latency: got %0d exp %0d", nm, at[0] - c0, 3); end
         for (int i = 0; i < nacks; i++) begin
            while (end_mask[exp_c]) exp_c = (exp_c + 1) % 4;
            checks++; if (order[i] != exp_c) begin errors++; $display("FAIL %s_order[%0d]: got %0d exp %0d", nm, i, order[i], exp_c); end
            if (i > 0) begin
               checks++; if (at[i] - at[i-1] != 3) begin errors++; $display("FAIL %s_gap[%0d]: got %0d exp 3", nm, i, at[i] - at[i-1]); end
            end
            exp_c = (exp_c + 1) % 4;
         end
      end
      req = '0; en = '0; step();
   endtask

   task automatic test_contention();
      run_contention("rr4", 4'b0000, 5, 15);
   endtask

   task automatic test_end_fair();
      run_contention("endfair", 4'b0100, 6, 18);
   endtask

   task automatic test_reset_mid();
      rst = 1'b1; step(); rst = 1'b0;
      req[0] = 1'b1; we[0] = 1'b1; addr[0] = 12'h020; wdata[0] = 32'h12345678;
      step();
      checks++; if (mem_we !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL rm_access: got we %b busy %b exp 1 1", mem_we, busy); end
      rst = 1'b1; req = '0;
      step();
      rst = 1'b0;
      checks++; if (mem_we !== 1'b0 || busy !== 1'b0 || ack !== 4'b0 || grant_id !== 2'd0)
         begin errors++; $display("FAIL rm_reset: got we %b busy %b ack %b gid %0d exp 0 0 0000 0", mem_we, busy, ack, grant_id); end
      checks++; if (mem_addr !== '0 || mem_wdata !== '0 || rdata !== '0)
         begin errors++; $display("FAIL rm_regs: got addr %h wdata %h rdata %h exp 0", mem_addr, mem_wdata, rdata); end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (ack !== 4'b0) begin errors++; $display("FAIL rm_noack: got %b exp 0000", ack); end
      end
   endtask

   task automatic test_held();
      int at[$];
      int c0;
      rst = 1'b1; step(); rst = 1'b0; c0 = cyc;
      req[3] = 1'b1; we[3] = 1'b0; addr[3] = 12'h040;
      for (int i = 0; i < 21; i++) begin
         step();
         if (ack[3]) at.push_back(cyc);
      end
      checks++;
      if (at.size() != 5) begin errors++; $display("FAIL held_count: got %0d exp 5", at.size()); end
      else begin
         checks++; if (at[0] != c0 + 3) begin errors++; $display("FAIL held_first: got %0d exp 3", at[0] - c0); end
         for (int i = 1; i < 5; i++) begin
            checks++; if (at[i] - at[i-1] != 4) begin errors++; $display("FAIL held_gap[%0d]: got %0d exp 4", i, at[i] - at[i-1]); end
         end
      end
      req = '0; step();
   endtask

   task automatic test_random();
      logic [3:0] pend;
      int k;
      pend = '0;
      for (int t = 0; t < 600; t++) begin
         rst = (t == 0) || ($urandom_range(0, 79) == 0);
         for (int c = 0; c < 4; c++) begin
            if (exp_ack[cyc][c]) pend[c] = 1'b0;
            if (!pend[c] && $urandom_range(0, 3) == 0) begin
               pend[c] = 1'b1; we[c] = 1'($urandom);
               addr[c] = AW'($urandom_range(0, 7)); wdata[c] = $urandom;
            end
            req[c] = pend[c];
            if ($urandom_range(0, 15) == 0) en[c] = ~en[c];
         end
         model_edge(cyc + 1);
         step();
         k = cyc;
         for (int c = 0; c < 4; c++) if (pend_cyc[c] == k) m_rd[c] = pend_val[c];
         checks++; if (ack !== exp_ack[k]) begin errors++; $display("FAIL rnd_ack@%0d: got %b exp %b", k, ack, exp_ack[k]); end
         checks++; if (busy !== exp_busy[k]) begin errors++; $display("FAIL rnd_busy@%0d: got %b exp %b", k, busy, exp_busy[k]); end
         checks++; if (mem_we !== exp_we[k]) begin errors++; $display("FAIL rnd_we@%0d: got %b exp %b", k, mem_we, exp_we[k]); end
         checks++; if (grant_id !== exp_gid[k]) begin errors++; $display("FAIL rnd_gid@%0d: got %0d exp %0d", k, grant_id, exp_gid[k]); end
         if (exp_g[k]) begin
            checks++; if (mem_addr !== exp_addr[k] || mem_wdata !== exp_wd[k])
               begin errors++; $display("FAIL rnd_cmd@%0d: got %h/%h exp %h/%h", k, mem_addr, mem_wdata, exp_addr[k], exp_wd[k]); end
         end
         checks++; if (rdata !== m_rd) begin errors++; $display("FAIL rnd_rdata@%0d: got %h exp %h", k, rdata, m_rd); end
      end
      rst = 1'b0; req = '0; en = '0;
   endtask

   initial begin
      for (int i = 0; i < MAXC; i++) begin
         exp_ack[i] = '0; exp_busy[i] = 0; exp_we[i] = 0; exp_g[i] = 0;
         exp_addr[i] = '0; exp_wd[i] = '0; exp_gid[i] = '0;
      end
      for (int i = 0; i < MEMSZ; i++) ref_mem[i] = DW'(i) * 32'h9E3779B1;
      for (int c = 0; c < 4; c++) begin pend_cyc[c] = -1; pend_val[c] = '0; end
      @(negedge clk);
      test_reset();
      test_single_write();
      test_readback();
      test_contention();
      test_end_fair();
      test_reset_mid();
      test_held();
      // Directed writes touched 0x010/0x020; mirror them in the model memory.
      ref_mem[12'h010] = 32'hDEADBEEF;
      ref_mem[12'h020] = 32'h12345678;
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
